// File: rtl/icache_ctrl.sv
// ============================================================================
// Module   : icache_ctrl
// Brief    : Control FSM for a 128-set, 8-word-line direct-mapped I-cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int SETS       = 128
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    output logic [6:0]  tag_qindex,
    output logic [19:0] tag_qtag,
    input  logic        tag_hit,
    output logic        tag_wen,
    output logic [6:0]  tag_windex,
    output logic [19:0] tag_wtag,
    output logic        tag_valid,
    output logic [9:0]  data_raddr,
    input  logic [31:0] data_rdata,
    output logic        data_wen,
    output logic [9:0]  data_waddr,
    output logic [31:0] data_wdata,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
);

    localparam int BEAT_W  = $clog2(LINE_WORDS);
    localparam int INDEX_W = $clog2(SETS);
    localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(SETS - 1);

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_LOOKUP  = 3'd2;
    localparam logic [2:0] S_MISS    = 3'd3;
    localparam logic [2:0] S_REFILL  = 3'd4;
    localparam logic [2:0] S_RESPOND = 3'd5;

    logic [2:0]         state_q,    state_d;
    logic [INDEX_W-1:0] init_cnt_q, init_cnt_d;
    logic [BEAT_W-1:0]  beat_q,     beat_d;
    logic [29:0]        req_addr_q, req_addr_d;   // word address, cpu_addr[31:2]
    logic [31:0]        crit_q,     crit_d;
    logic [31:0]        rdata_q,    rdata_d;

    logic [19:0] w_req_tag;
    logic [6:0]  w_req_index;
    logic [2:0]  w_req_word;
    logic        w_unused_addr;

    assign w_req_tag     = req_addr_q[29:10];
    assign w_req_index   = req_addr_q[9:3];
    assign w_req_word    = req_addr_q[2:0];
    assign w_unused_addr = ^cpu_addr[1:0];

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        beat_d     = beat_q;
        req_addr_d = req_addr_q;
        crit_d     = crit_q;
        case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_SET) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (cpu_req) begin
                    req_addr_d = cpu_addr[31:2];
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = tag_hit ? S_IDLE : S_MISS;
            S_MISS: begin
                if (rd_rdy) begin
                    beat_d  = '0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (ret_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == w_req_word) crit_d = ret_data;
                    if (ret_last) state_d = S_RESPOND;
                end
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_INIT;
        endcase
    end

    always_comb begin
        cpu_addr_ok = 1'b0;
        cpu_data_ok = 1'b0;
        cpu_rdata   = rdata_q;
        tag_qindex  = w_req_index;
        tag_qtag    = w_req_tag;
        data_raddr  = {w_req_index, w_req_word};
        tag_wen     = 1'b0;
        tag_windex  = '0;
        tag_wtag    = '0;
        tag_valid   = 1'b0;
        data_wen    = 1'b0;
        data_waddr  = '0;
        data_wdata  = '0;
        rd_req      = 1'b0;
        rd_addr     = '0;
        case (state_q)
            S_INIT: begin
                // Gated so the sweep does not write while reset is still held.
                tag_wen    = resetn;
                tag_windex = init_cnt_q;
            end
            S_IDLE: cpu_addr_ok = 1'b1;
            S_LOOKUP: begin
                if (tag_hit) begin
                    cpu_data_ok = 1'b1;
                    cpu_rdata   = data_rdata;
                end
            end
            S_MISS: begin
                rd_req  = 1'b1;
                rd_addr = {w_req_tag, w_req_index, 5'b0};
            end
            S_REFILL: begin
                if (ret_valid) begin
                    data_wen   = 1'b1;
                    data_waddr = {w_req_index, beat_q};
                    data_wdata = ret_data;
                    if (ret_last) begin
                        tag_wen    = 1'b1;
                        tag_windex = w_req_index;
                        tag_wtag   = w_req_tag;
                        tag_valid  = 1'b1;
                    end
                end
            end
            S_RESPOND: begin
                cpu_data_ok = 1'b1;
                cpu_rdata   = crit_q;
            end
            default: ;
        endcase
    end

    assign rdata_d = cpu_data_ok ? cpu_rdata : rdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            beat_q     <= '0;
            req_addr_q <= '0;
            crit_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            beat_q     <= beat_d;
            req_addr_q <= req_addr_d;
            crit_q     <= crit_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache_ctrl.sv
// ============================================================================
// Module   : tb_icache_ctrl
// Brief    : Directed self-checking bench for icache_ctrl with tag/data models.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_addr_ok;
    logic        cpu_data_ok;
    logic [31:0] cpu_rdata;
    logic [6:0]  tag_qindex;
    logic [19:0] tag_qtag;
    logic        tag_hit;
    logic        tag_wen;
    logic [6:0]  tag_windex;
    logic [19:0] tag_wtag;
    logic        tag_valid;
    logic [9:0]  data_raddr;
    logic [31:0] data_rdata;
    logic        data_wen;
    logic [9:0]  data_waddr;
    logic [31:0] data_wdata;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    icache_ctrl #(.LINE_WORDS(8), .SETS(128)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
        .tag_qindex(tag_qindex), .tag_qtag(tag_qtag), .tag_hit(tag_hit),
        .tag_wen(tag_wen), .tag_windex(tag_windex), .tag_wtag(tag_wtag), .tag_valid(tag_valid),
        .data_raddr(data_raddr), .data_rdata(data_rdata),
        .data_wen(data_wen), .data_waddr(data_waddr), .data_wdata(data_wdata),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
    );

    // Tag array and data RAM models; tags start valid with a matching tag so
    // only the power-on sweep can make the first fetch miss.
    logic        tv [128];
    logic [19:0] tt [128];
    logic [31:0] dram [1024];
    logic        model_ready = 1'b0;

    assign tag_hit    = tv[tag_qindex] && (tt[tag_qindex] == tag_qtag);
    assign data_rdata = dram[data_raddr];

    always @(posedge clk) begin
        if (!model_ready) begin
            for (int i = 0; i < 128; i++) begin
                tv[i] <= 1'b1;
                tt[i] <= 20'hBFC00;
            end
            for (int i = 0; i < 1024; i++) dram[i] <= 32'h0;
            model_ready <= 1'b1;
        end else begin
            if (tag_wen) begin
                tv[tag_windex] <= tag_valid;
                tt[tag_windex] <= tag_wtag;
            end
            if (data_wen) dram[data_waddr] <= data_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered at the negedge on which resetn was released.
    task automatic init_sweep();
        for (int i = 0; i < 128; i++) begin
            #1;
            chk("init_wen", tag_wen, 1);
            chk("init_idx", tag_windex, i);
            chk("init_valid", tag_valid, 0);
            chk("init_addr_ok", cpu_addr_ok, 0);
            chk("init_dwen", data_wen, 0);
            @(negedge clk);
        end
        #1;
        chk("post_init_addr_ok", cpu_addr_ok, 1);
        chk("post_init_wen", tag_wen, 0);
    endtask

    // Leaves the bench at LOOKUP + 1ns.
    task automatic fetch_accept(input logic [31:0] a);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = a;
        #1;
        chk("accept_addr_ok", cpu_addr_ok, 1);
        chk("accept_data_ok", cpu_data_ok, 0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("lookup_addr_ok", cpu_addr_ok, 0);
    endtask

    task automatic do_hit(input logic [31:0] a, input logic [31:0] exp);
        fetch_accept(a);
        chk("hit_data_ok", cpu_data_ok, 1);
        chk("hit_rdata", cpu_rdata, exp);
        @(negedge clk);
        #1;
        chk("hit_no_rdreq", rd_req, 0);
        chk("hit_after_data_ok", cpu_data_ok, 0);
        chk("hit_rdata_hold", cpu_rdata, exp);
        chk("hit_idle", cpu_addr_ok, 1);
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [31:0] exp_rdaddr,
                           input logic [6:0] exp_idx, input logic [19:0] exp_tag,
                           input logic [31:0] base, input logic [31:0] stp,
                           input logic gap, input logic [31:0] exp_crit);
        fetch_accept(a);
        chk("miss_data_ok", cpu_data_ok, 0);
        @(negedge clk);
        #1;
        chk("miss_rd_req", rd_req, 1);
        chk("miss_rd_addr", rd_addr, exp_rdaddr);
        @(negedge clk);
        rd_rdy = 1'b1;
        #1;
        chk("miss_rd_req_hold", rd_req, 1);
        chk("miss_rd_addr_hold", rd_addr, exp_rdaddr);
        @(negedge clk);
        rd_rdy = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (gap) begin
                ret_valid = 1'b0;
                ret_last  = 1'b0;
                #1;
                chk("gap_dwen", data_wen, 0);
                chk("gap_twen", tag_wen, 0);
                @(negedge clk);
            end
            ret_valid = 1'b1;
            ret_last  = (b == 7);
            ret_data  = base + stp * b;
            #1;
            chk("beat_dwen", data_wen, 1);
            chk("beat_waddr", data_waddr, {exp_idx, 3'(b)});
            chk("beat_wdata", data_wdata, base + stp * b);
            chk("beat_twen", tag_wen, (b == 7));
            chk("beat_data_ok", cpu_data_ok, 0);
            if (b == 7) begin
                chk("fill_windex", tag_windex, exp_idx);
                chk("fill_wtag", tag_wtag, exp_tag);
                chk("fill_valid", tag_valid, 1);
            end
            @(negedge clk);
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        #1;
        chk("resp_data_ok", cpu_data_ok, 1);
        chk("resp_rdata", cpu_rdata, exp_crit);
        chk("resp_addr_ok", cpu_addr_ok, 0);
        chk("resp_dwen", data_wen, 0);
        @(negedge clk);
        #1;
        chk("resp_done", cpu_data_ok, 0);
        chk("resp_idle", cpu_addr_ok, 1);
        chk("resp_hold", cpu_rdata, exp_crit);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        resetn    = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = 32'h0;
        rd_rdy    = 1'b0;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_addr_ok", cpu_addr_ok, 0);
        chk("rst_data_ok", cpu_data_ok, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_twen", tag_wen, 0);
        chk("rst_dwen", data_wen, 0);
        chk("rst_rd_req", rd_req, 0);
        @(negedge clk);
        resetn = 1'b1;
        init_sweep();

        // Cold miss, critical word 5.
        do_miss(32'hBFC0_0014, 32'hBFC0_0000, 7'd0, 20'hBFC00,
                32'h11, 32'h11, 1'b0, 32'h66);
        do_hit(32'hBFC0_0018, 32'h77);
        // Conflict miss on set 0, then the old line misses again.
        do_miss(32'hBFC0_1000, 32'hBFC0_1000, 7'd0, 20'hBFC01,
                32'hA0, 32'h1, 1'b0, 32'hA0);
        do_miss(32'hBFC0_0000, 32'hBFC0_0000, 7'd0, 20'hBFC00,
                32'h11, 32'h11, 1'b0, 32'h11);
        // Alternate-cycle beats, critical word 7 in set 15.
        do_miss(32'h8000_01FC, 32'h8000_01E0, 7'd15, 20'h80000,
                32'h100, 32'h1, 1'b1, 32'h107);
        do_hit(32'h8000_01FC, 32'h107);
        do_hit(32'h8000_01E0, 32'h100);

        // Reset asserted during beat 4 of a refill.
        fetch_accept(32'h8000_0020);
        @(negedge clk);
        #1;
        chk("mid_rd_req", rd_req, 1);
        @(negedge clk);
        rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0;
        for (int b = 0; b < 4; b++) begin
            ret_valid = 1'b1;
            ret_data  = 32'h300 + b;
            @(negedge clk);
        end
        ret_valid = 1'b1;
        ret_data  = 32'h304;
        #1;
        chk("mid_beat4_dwen", data_wen, 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_dwen", data_wen, 0);
        chk("mid_rst_twen", tag_wen, 0);
        chk("mid_rst_rdata", cpu_rdata, 0);
        chk("mid_rst_addr_ok", cpu_addr_ok, 0);
        chk("mid_rst_rd_req", rd_req, 0);
        @(negedge clk);
        resetn = 1'b1;
        init_sweep();
        ret_valid = 1'b0;
        do_miss(32'h8000_0020, 32'h8000_0020, 7'd1, 20'h80000,
                32'h200, 32'h1, 1'b0, 32'h200);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
